// File: rtl/apb4_master_bridge.sv
// Single-outstanding APB4 requester: a valid/ready request becomes one SETUP/ACCESS
// transfer, and the completer's answer (or a timeout) is returned on a valid/ready response.
module apb4_master_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,   // pstrb is fixed at 4 bits, so this must stay 32
    parameter int TIMEOUT    = 256   // 0 lets ACCESS wait forever
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [3:0]            req_strb_i,
    input  logic [2:0]            req_prot_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [2:0]            pprot_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic [3:0]            pstrb_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        state;
    logic [CW-1:0] to_cnt;
    logic          timeout_hit;

    assign req_ready_o = (state == IDLE);

    // Counter holds the number of ACCESS cycles already spent without pready.
    assign timeout_hit = (TIMEOUT != 0) && !pready_i && (to_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            to_cnt        <= '0;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            pwrite_o      <= 1'b0;
            paddr_o       <= '0;
            pwdata_o      <= '0;
            pstrb_o       <= 4'b0000;
            pprot_o       <= 3'b000;
            rsp_valid_o   <= 1'b0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            rsp_rdata_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        paddr_o  <= req_addr_i;
                        pwrite_o <= req_write_i;
                        pwdata_o <= req_wdata_i;
                        pprot_o  <= req_prot_i;
                        pstrb_o  <= req_write_i ? req_strb_i : 4'b0000;
                        psel_o   <= 1'b1;
                        to_cnt   <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    penable_o <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (pready_i) begin
                        psel_o        <= 1'b0;
                        penable_o     <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_err_o     <= pslverr_i;
                        rsp_timeout_o <= 1'b0;
                        rsp_rdata_o   <= (!pwrite_o && !pslverr_i) ? prdata_i : '0;
                        state         <= RESP;
                    end else if (timeout_hit) begin
                        psel_o        <= 1'b0;
                        penable_o     <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_err_o     <= 1'b1;
                        rsp_timeout_o <= 1'b1;
                        rsp_rdata_o   <= '0;
                        state         <= RESP;
                    end else begin
                        to_cnt <= to_cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb4_master_bridge.sv
// Bench for apb4_master_bridge: two instances (TIMEOUT 8 and 4) driven from a per-transfer
// timeline model; one process compares every cycle against the model's expectations.
module tb_apb4_master_bridge;
    localparam int TO0 = 8;
    localparam int TO1 = 4;

    typedef struct {
        logic        req_ready, psel, penable, rsp_valid, zero;
        logic [31:0] paddr, pwdata, rdata;
        logic        pwrite, err, tout;
        logic [3:0]  pstrb;
        logic [2:0]  pprot;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid [2], req_write [2], rsp_ready [2], pready [2], pslverr [2];
    logic [31:0] req_addr [2], req_wdata [2], prdata [2];
    logic [3:0]  req_strb [2];
    logic [2:0]  req_prot [2];
    logic        req_ready [2], rsp_valid [2], rsp_err [2], rsp_tout [2];
    logic        psel [2], penable [2], pwrite [2];
    logic [31:0] rsp_rdata [2], paddr [2], pwdata [2];
    logic [3:0]  pstrb [2];
    logic [2:0]  pprot [2];

    exp_t ex [2];
    int   n_chk = 0, n_pass = 0;
    int   acc_run [2], lat_run [2], obs_acc [2], obs_lat [2];
    logic prev_rv [2];
    logic [31:0] obs_rdata [2];
    logic obs_err [2], obs_tout [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        apb4_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(gi == 0 ? TO0 : TO1)) u_dut (
            .clk_i(clk), .rst_i(rst),
            .req_valid_i(req_valid[gi]), .req_ready_o(req_ready[gi]),
            .req_addr_i(req_addr[gi]), .req_write_i(req_write[gi]),
            .req_wdata_i(req_wdata[gi]), .req_strb_i(req_strb[gi]), .req_prot_i(req_prot[gi]),
            .rsp_valid_o(rsp_valid[gi]), .rsp_ready_i(rsp_ready[gi]),
            .rsp_rdata_o(rsp_rdata[gi]), .rsp_err_o(rsp_err[gi]), .rsp_timeout_o(rsp_tout[gi]),
            .paddr_o(paddr[gi]), .pprot_o(pprot[gi]), .psel_o(psel[gi]), .penable_o(penable[gi]),
            .pwrite_o(pwrite[gi]), .pwdata_o(pwdata[gi]), .pstrb_o(pstrb[gi]),
            .prdata_i(prdata[gi]), .pready_i(pready[gi]), .pslverr_i(pslverr[gi])
        );
    end

    task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL u%0d.%s: got 0x%08h expected 0x%08h at %0t", i, nm, act, exp, $time);
    endtask

    task automatic phase(input int i, input logic rr, input logic ps, input logic pe, input logic rv);
        ex[i].req_ready = rr;
        ex[i].psel      = ps;
        ex[i].penable   = pe;
        ex[i].rsp_valid = rv;
    endtask

    task automatic set_zero(input int i);
        ex[i] = '{req_ready: 1'b1, zero: 1'b1, default: '0};
    endtask

    // One transfer on instance i: w = pready-low ACCESS cycles before pready,
    // rdel = response back-pressure cycles, hold = keep req_valid high while waiting in RESP.
    task automatic xfer(input int i, input logic [31:0] a, input logic wr, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] pr, input int w, input logic se,
                        input logic [31:0] rd, input int rdel, input logic hold);
        int   to, nacc;
        logic tmo;
        to   = (i == 0) ? TO0 : TO1;
        tmo  = (to != 0) && (w >= to);
        nacc = tmo ? to : w + 1;
        @(negedge clk);
        req_valid[i] = 1'b1; req_addr[i] = a; req_write[i] = wr; req_wdata[i] = wd;
        req_strb[i] = st; req_prot[i] = pr; pready[i] = 1'b0; rsp_ready[i] = 1'b0;
        ex[i].zero  = 1'b0;
        ex[i].paddr = a; ex[i].pwrite = wr; ex[i].pwdata = wd; ex[i].pprot = pr;
        ex[i].pstrb = wr ? st : 4'b0000;
        ex[i].err   = tmo | se;
        ex[i].tout  = tmo;
        ex[i].rdata = (tmo || wr || se) ? 32'h0 : rd;
        phase(i, 0, 1, 0, 0);
        @(negedge clk);
        req_valid[i] = 1'b0; req_addr[i] = $urandom; req_wdata[i] = $urandom; req_strb[i] = 4'($urandom);
        phase(i, 0, 1, 1, 0);
        for (int k = 0; k < nacc; k++) begin
            @(negedge clk);
            pready[i]  = (k == w);
            pslverr[i] = (k == w) ? se : 1'($urandom);
            prdata[i]  = (k == w) ? rd : $urandom;
            if (k == nacc - 1) phase(i, 0, 0, 0, 1);
            else phase(i, 0, 1, 1, 0);
        end
        for (int r = 0; r <= rdel; r++) begin
            @(negedge clk);
            pready[i]    = 1'b0;
            pslverr[i]   = 1'($urandom);
            prdata[i]    = $urandom;
            rsp_ready[i] = (r == rdel);
            req_valid[i] = hold && (r < rdel);
            if (r == rdel) phase(i, 1, 0, 0, 0);
            else phase(i, 0, 0, 0, 1);
        end
    endtask

    // Per-cycle compare, #1 after the active edge; also records observed ACCESS length,
    // accept-to-response latency and the response fields for the literal checks.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                chk(i, "req_ready", 32'(req_ready[i]), 32'(ex[i].req_ready));
                chk(i, "psel",      32'(psel[i]),      32'(ex[i].psel));
                chk(i, "penable",   32'(penable[i]),   32'(ex[i].penable));
                chk(i, "rsp_valid", 32'(rsp_valid[i]), 32'(ex[i].rsp_valid));
                if (ex[i].psel || ex[i].zero) begin
                    chk(i, "paddr",  paddr[i],          ex[i].paddr);
                    chk(i, "pwrite", 32'(pwrite[i]),    32'(ex[i].pwrite));
                    chk(i, "pwdata", pwdata[i],         ex[i].pwdata);
                    chk(i, "pstrb",  32'(pstrb[i]),     32'(ex[i].pstrb));
                    chk(i, "pprot",  32'(pprot[i]),     32'(ex[i].pprot));
                end
                if (ex[i].rsp_valid || ex[i].zero) begin
                    chk(i, "rsp_rdata",   rsp_rdata[i],      ex[i].rdata);
                    chk(i, "rsp_err",     32'(rsp_err[i]),   32'(ex[i].err));
                    chk(i, "rsp_timeout", 32'(rsp_tout[i]),  32'(ex[i].tout));
                end
                if (psel[i] && !penable[i]) begin
                    acc_run[i] = 0;
                    lat_run[i] = 1;
                end else begin
                    lat_run[i]++;
                    if (psel[i] && penable[i]) acc_run[i]++;
                end
                if (rsp_valid[i] && !prev_rv[i]) begin
                    obs_lat[i]   = lat_run[i];
                    obs_acc[i]   = acc_run[i];
                    obs_rdata[i] = rsp_rdata[i];
                    obs_err[i]   = rsp_err[i];
                    obs_tout[i]  = rsp_tout[i];
                end
                prev_rv[i] = rsp_valid[i];
            end
        end
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 0; req_write[i] = 0; rsp_ready[i] = 0; pready[i] = 0; pslverr[i] = 0;
            req_addr[i] = 0; req_wdata[i] = 0; prdata[i] = 0; req_strb[i] = 0; req_prot[i] = 0;
            acc_run[i] = 0; lat_run[i] = 0; obs_acc[i] = 0; obs_lat[i] = 0; prev_rv[i] = 0;
            obs_rdata[i] = 0; obs_err[i] = 0; obs_tout[i] = 0;
            set_zero(i);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Write with immediate pready: 3-cycle latency, single ACCESS cycle
        xfer(0, 32'h4, 1, 32'hDEADBEEF, 4'hF, 3'b010, 0, 0, 32'hA5A5A5A5, 0, 0);
        chk(0, "t1_latency", 32'(obs_lat[0]), 32'd3);
        chk(0, "t1_access",  32'(obs_acc[0]), 32'd1);
        chk(0, "t1_rdata",   obs_rdata[0],    32'h0);
        // Read with 5 wait states
        xfer(0, 32'h8, 0, 32'h55AA55AA, 4'hF, 3'b000, 5, 0, 32'h1234, 0, 0);
        chk(0, "t2_access", 32'(obs_acc[0]), 32'd6);
        chk(0, "t2_rdata",  obs_rdata[0],    32'h1234);
        // Read with slave error
        xfer(0, 32'hC, 0, 32'h0, 4'h3, 3'b111, 0, 1, 32'hFFFF0000, 0, 0);
        chk(0, "t3_err",   32'(obs_err[0]),  32'd1);
        chk(0, "t3_tout",  32'(obs_tout[0]), 32'd0);
        chk(0, "t3_rdata", obs_rdata[0],     32'h0);
        // TIMEOUT=4: stuck pready, then pready on the 4th ACCESS cycle
        xfer(1, 32'h10, 0, 32'h0, 4'h0, 3'b001, 20, 0, 32'h77, 1, 0);
        chk(1, "t4_access", 32'(obs_acc[1]), 32'd4);
        chk(1, "t4_tout",   32'(obs_tout[1]), 32'd1);
        chk(1, "t4_rdata",  obs_rdata[1],    32'h0);
        xfer(1, 32'h14, 0, 32'h0, 4'h0, 3'b001, 3, 0, 32'h99, 0, 0);
        chk(1, "t5_access", 32'(obs_acc[1]), 32'd4);
        chk(1, "t5_tout",   32'(obs_tout[1]), 32'd0);
        chk(1, "t5_rdata",  obs_rdata[1],    32'h99);
        // Long response back-pressure with a pending request, then back-to-back
        xfer(0, 32'h20, 1, 32'h0BADF00D, 4'h5, 3'b100, 1, 0, 32'h0, 10, 1);
        xfer(0, 32'h24, 0, 32'h0, 4'hF, 3'b000, 0, 0, 32'hCAFEF00D, 0, 0);
        xfer(0, 32'h28, 1, 32'h13579BDF, 4'h8, 3'b000, 0, 0, 32'h0, 0, 0);

        // Reset in the middle of ACCESS abandons the transfer
        @(negedge clk);
        req_valid[1] = 1; req_addr[1] = 32'h30; req_write[1] = 1; req_wdata[1] = 32'h1;
        req_strb[1] = 4'hF; req_prot[1] = 3'b000;
        ex[1].zero = 0; ex[1].paddr = 32'h30; ex[1].pwrite = 1; ex[1].pwdata = 32'h1;
        ex[1].pstrb = 4'hF; ex[1].pprot = 3'b000;
        phase(1, 0, 1, 0, 0);
        @(negedge clk);
        req_valid[1] = 0;
        phase(1, 0, 1, 1, 0);
        @(negedge clk);
        rst = 1'b1; pready[1] = 1'b0;
        set_zero(0); set_zero(1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Randomized transfers on both instances
        for (int n = 0; n < 40; n++) begin
            xfer(int'($urandom_range(0, 1)), $urandom, 1'($urandom), $urandom, 4'($urandom),
                 3'($urandom), int'($urandom_range(0, 10)), ($urandom_range(0, 3) == 0),
                 $urandom, int'($urandom_range(0, 3)), 1'($urandom));
        end
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
